// File: rtl/branch_predictor_bht.sv
// Tagged branch history table: combinational decode-stage lookup, MEM-stage counter training.
// Optional lookup/mispredict statistics counters are built when BPRED_STATS_EN is defined.

module bht_entry #(
  parameter int CNT_W  = 2,
  parameter int TW     = 8,
  parameter bit TAG_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_we,
  input  logic [TW-1:0]    i_tag,
  input  logic             i_taken,
  output logic             o_valid,
  output logic [TW-1:0]    o_tag,
  output logic [CNT_W-1:0] o_cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] WEAK_T  = CNT_W'(1) << (CNT_W-1);
  localparam logic [CNT_W-1:0] WEAK_NT = WEAK_T - CNT_W'(1);

  logic             r_valid;
  logic [TW-1:0]    r_tag;
  logic [CNT_W-1:0] r_cnt;
  logic             w_hit;

  assign w_hit = r_valid & (!TAG_EN || (r_tag == i_tag));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_cnt   <= WEAK_NT;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_we) begin
      r_valid <= 1'b1;
      r_tag   <= i_tag;
      if (w_hit) begin
        if (i_taken && r_cnt != CNT_MAX)   r_cnt <= r_cnt + CNT_W'(1);
        else if (!i_taken && r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
      end else begin
        // a miss re-allocates the slot at the weak state matching the outcome
        r_cnt <= i_taken ? WEAK_T : WEAK_NT;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_tag   = r_tag;
  assign o_cnt   = r_cnt;
endmodule

module branch_predictor_bht #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int TAG_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  input  logic [31:0] lookup_offset,
  output logic        predict_taken,
  output logic [31:0] predict_target,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic        update_mispredict,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_mispredicts
);
  localparam int IDX = $clog2(ENTRIES);
  localparam int TW  = (TAG_W > 0) ? TAG_W : 1;

  logic [ENTRIES-1:0]            w_valid;
  logic [ENTRIES-1:0][TW-1:0]    w_tag;
  logic [ENTRIES-1:0][CNT_W-1:0] w_cnt;
  logic [ENTRIES-1:0]            w_we;
  logic [IDX-1:0]                w_lk_idx, w_up_idx;
  logic [TW-1:0]                 w_lk_tag, w_up_tag;
  logic                          w_lk_hit;
  logic                          w_unused;

  assign w_lk_idx = lookup_pc[IDX+1:2];
  assign w_up_idx = update_pc[IDX+1:2];

  generate
    if (TAG_W > 0) begin : g_tag
      assign w_lk_tag = lookup_pc[IDX+TAG_W+1:IDX+2];
      assign w_up_tag = update_pc[IDX+TAG_W+1:IDX+2];
    end else begin : g_notag
      assign w_lk_tag = '0;
      assign w_up_tag = '0;
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_ent
      assign w_we[gi] = update_valid && (w_up_idx == IDX'(gi));
      bht_entry #(.CNT_W(CNT_W), .TW(TW), .TAG_EN(TAG_W > 0)) u_ent (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (clear),
        .i_we    (w_we[gi]),
        .i_tag   (w_up_tag),
        .i_taken (update_taken),
        .o_valid (w_valid[gi]),
        .o_tag   (w_tag[gi]),
        .o_cnt   (w_cnt[gi])
      );
    end
  endgenerate

  // reads the registered entry, so a same-cycle update to this slot is not visible yet
  assign w_lk_hit       = w_valid[w_lk_idx] & ((TAG_W == 0) || (w_tag[w_lk_idx] == w_lk_tag));
  assign predict_taken  = lookup_valid & w_lk_hit & w_cnt[w_lk_idx][CNT_W-1];
  assign predict_target = lookup_pc + lookup_offset;

`ifdef BPRED_STATS_EN
  logic [31:0] r_stat_lk, r_stat_mis;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_lk  <= '0;
      r_stat_mis <= '0;
    end else begin
      if (lookup_valid)                      r_stat_lk  <= r_stat_lk + 32'd1;
      if (update_valid && update_mispredict) r_stat_mis <= r_stat_mis + 32'd1;
    end
  end
  assign stat_lookups     = r_stat_lk;
  assign stat_mispredicts = r_stat_mis;
  assign w_unused         = ^update_pc;
`else
  assign stat_lookups     = 32'b0;
  assign stat_mispredicts = 32'b0;
  assign w_unused         = ^{update_pc, update_mispredict};
`endif
endmodule

// File: tb/tb_branch_predictor_bht.sv
// Vector table plus scoreboard queue bench for branch_predictor_bht (default parameters).
module tb_branch_predictor_bht;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        lookup_valid;
  logic [31:0] lookup_pc, lookup_offset;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken, update_mispredict;
  logic [31:0] stat_lookups, stat_mispredicts;

  always #5 clk = ~clk;

  branch_predictor_bht dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .lookup_offset(lookup_offset),
    .predict_taken(predict_taken), .predict_target(predict_target),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_mispredict(update_mispredict),
    .stat_lookups(stat_lookups), .stat_mispredicts(stat_mispredicts)
  );

  typedef struct {
    logic        lk_v;
    logic [31:0] lk_pc, lk_off;
    logic        up_v;
    logic [31:0] up_pc;
    logic        up_t, up_mis, clr;
    logic        exp_t;
    logic [31:0] exp_tgt;
    string       name;
  } vec_t;

  vec_t tbl[28];
  vec_t sb[$];
  int total = 0, bad = 0;
  int n_lk = 0, n_mis = 0;

  function automatic vec_t mk(input logic lv, input logic [31:0] lp, input logic [31:0] lo,
                              input logic uv, input logic [31:0] up, input logic ut,
                              input logic um, input logic cl, input logic et,
                              input logic [31:0] eg, input string nm);
    vec_t v;
    v.lk_v = lv; v.lk_pc = lp; v.lk_off = lo; v.up_v = uv; v.up_pc = up;
    v.up_t = ut; v.up_mis = um; v.clr = cl; v.exp_t = et; v.exp_tgt = eg; v.name = nm;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    clear = 0; lookup_valid = 0; lookup_pc = 0; lookup_offset = 0;
    update_valid = 0; update_pc = 0; update_taken = 0; update_mispredict = 0;
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    lookup_valid = v.lk_v; lookup_pc = v.lk_pc; lookup_offset = v.lk_off;
    update_valid = v.up_v; update_pc = v.up_pc; update_taken = v.up_t;
    update_mispredict = v.up_mis; clear = v.clr;
    sb.push_back(v);
    if (v.lk_v) n_lk++;
    if (v.up_v && v.up_mis) n_mis++;
    #2;
    e = sb.pop_front();
    chk({e.name, ".taken"}, 32'(predict_taken), 32'(e.exp_t));
    chk({e.name, ".target"}, predict_target, e.exp_tgt);
  endtask

  task automatic chk_stats(input string nm);
`ifdef BPRED_STATS_EN
    chk({nm, ".lookups"}, stat_lookups, 32'(n_lk));
    chk({nm, ".mispredicts"}, stat_mispredicts, 32'(n_mis));
`else
    chk({nm, ".lookups"}, stat_lookups, 32'h0);
    chk({nm, ".mispredicts"}, stat_mispredicts, 32'h0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //          lk  pc            off           up  upc       t  mis clr  exp target
    tbl[0]  = mk(1, 32'h40,       32'h10,       0, 32'h0,   0, 0, 0,   0, 32'h50,  "cold_lookup");
    tbl[1]  = mk(1, 32'h40,       32'h10,       1, 32'h40,  1, 0, 0,   0, 32'h50,  "alloc_taken");
    tbl[2]  = mk(1, 32'h40,       32'h4,        0, 32'h0,   0, 0, 0,   1, 32'h44,  "weak_taken");
    tbl[3]  = mk(1, 32'h40,       32'h10,       1, 32'h40,  0, 1, 0,   1, 32'h50,  "nt1");
    tbl[4]  = mk(1, 32'h40,       32'h10,       1, 32'h40,  0, 0, 0,   0, 32'h50,  "nt2");
    tbl[5]  = mk(1, 32'h40,       32'h10,       1, 32'h40,  0, 0, 0,   0, 32'h50,  "nt3_sat0");
    tbl[6]  = mk(1, 32'h40,       32'h10,       1, 32'h40,  1, 0, 0,   0, 32'h50,  "from0_taken");
    tbl[7]  = mk(1, 32'h40,       32'h10,       1, 32'h40,  1, 0, 0,   0, 32'h50,  "same_cycle_pre");
    tbl[8]  = mk(1, 32'h40,       32'h10,       0, 32'h0,   0, 0, 0,   1, 32'h50,  "same_cycle_post");
    tbl[9]  = mk(1, 32'h440,      32'h10,       0, 32'h0,   0, 0, 0,   0, 32'h450, "alias_miss");
    tbl[10] = mk(1, 32'h40,       32'h10,       1, 32'h440, 0, 1, 0,   1, 32'h50,  "alias_retag");
    tbl[11] = mk(1, 32'h40,       32'h10,       0, 32'h0,   0, 0, 0,   0, 32'h50,  "old_tag_miss");
    tbl[12] = mk(1, 32'h440,      32'h10,       0, 32'h0,   0, 0, 0,   0, 32'h450, "weak_nt");
    tbl[13] = mk(0, 32'h440,      32'h10,       1, 32'h440, 1, 0, 0,   0, 32'h450, "up_t1");
    tbl[14] = mk(1, 32'h440,      32'h10,       0, 32'h0,   0, 0, 0,   1, 32'h450, "cnt2");
    tbl[15] = mk(0, 32'h440,      32'h10,       1, 32'h440, 1, 0, 0,   0, 32'h450, "up_to3");
    tbl[16] = mk(0, 32'h440,      32'h10,       1, 32'h440, 1, 0, 0,   0, 32'h450, "up_sat3");
    tbl[17] = mk(1, 32'h440,      32'h10,       0, 32'h0,   0, 0, 0,   1, 32'h450, "sat_top");
    tbl[18] = mk(0, 32'hFFFFFFF0, 32'h20,       0, 32'h0,   0, 0, 0,   0, 32'h10,  "target_wrap");
    tbl[19] = mk(0, 32'h48,       32'h10,       1, 32'h48,  1, 0, 0,   0, 32'h58,  "alloc_idx2");
    tbl[20] = mk(1, 32'h48,       32'h10,       0, 32'h0,   0, 0, 0,   1, 32'h58,  "idx2_taken");
    tbl[21] = mk(0, 32'h440,      32'h10,       0, 32'h0,   0, 0, 0,   0, 32'h450, "no_lookup_valid");
    tbl[22] = mk(1, 32'h440,      32'h10,       1, 32'h80,  1, 0, 1,   1, 32'h450, "clear_cycle");
    tbl[23] = mk(1, 32'h440,      32'h10,       0, 32'h0,   0, 0, 0,   0, 32'h450, "cleared_idx0");
    tbl[24] = mk(1, 32'h48,       32'h10,       0, 32'h0,   0, 0, 0,   0, 32'h58,  "cleared_idx2");
    tbl[25] = mk(1, 32'h80,       32'h10,       0, 32'h0,   0, 0, 0,   0, 32'h90,  "clear_drops_update");
    tbl[26] = mk(0, 32'h48,       32'h10,       1, 32'h48,  1, 0, 0,   0, 32'h58,  "realloc");
    tbl[27] = mk(1, 32'h48,       32'hFFFFFFF0, 0, 32'h0,   0, 0, 0,   1, 32'h38,  "neg_offset");

    idle();
    rst_n = 0;
    lookup_valid = 1; lookup_pc = 32'h40; lookup_offset = 32'h10;
    #1;
    chk("reset.taken", 32'(predict_taken), 32'h0);
    chk("reset.target", predict_target, 32'h50);
    chk_stats("reset");
    @(negedge clk); @(negedge clk);
    idle();
    rst_n = 1;

    foreach (tbl[i]) apply(tbl[i]);
    @(negedge clk);
    idle();
    #1;
    chk_stats("after_table");

    // async reset in the middle of an update cycle
    apply(mk(0, 32'h48, 32'h0, 1, 32'h48, 1, 1, 0, 0, 32'h48, "pre_async"));
    @(negedge clk);
    lookup_valid = 1; lookup_pc = 32'h48; update_valid = 1; update_pc = 32'h48;
    update_taken = 1; update_mispredict = 1;
    #2 rst_n = 0;
    #1;
    chk("async_rst.taken", 32'(predict_taken), 32'h0);
    chk("async_rst.lookups", stat_lookups, 32'h0);
    chk("async_rst.mispredicts", stat_mispredicts, 32'h0);
    @(negedge clk);
    idle();
    rst_n = 1;
    n_lk = 0; n_mis = 0;
    apply(mk(1, 32'h48, 32'h8, 0, 32'h0, 0, 0, 0, 0, 32'h50, "post_rst_invalid"));

    n_lk = 0; n_mis = 0;
    @(negedge clk);
    rst_n = 0;
    #1 rst_n = 1;
    for (int k = 0; k < 5; k++)
      apply(mk(1, 32'h104, 32'h0, k < 2, 32'h208, 1, 1, 0, 0, 32'h104, "stats_run"));
    @(negedge clk);
    idle();
    #1;
    chk_stats("stats_5_2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
